// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Closes the loop of the 2-bit branch predictor. Every prediction made at
// fetch is pushed into a small in-order queue; when ID resolves the oldest
// branch, the actual outcome is compared with the recorded prediction. The
// unit emits a one-cycle predictor update strobe and, on a mispredict, a
// one-cycle flush together with the corrected next PC.
//
// Optional feature macro: BRU_STATS_EN
//   defined   -> saturating resolved / mispredict counters
//   undefined -> no counter flops, counter outputs tied to 0
//
// Parameters
//   DEPTH  in-flight prediction entries (power of two, >= 2)
//   PC_W   PC / target width
//   CNT_W  statistics counter width
//
// Ports
//   clk_i, rst_i (async, active low)
//   pred_valid_i/pred_taken_i/pred_target_i/pred_fallthru_i : push from IF
//   full_o                                                  : queue full
//   res_valid_i/res_taken_i                                 : resolve from ID
//   update_o/result_o                                       : predictor update
//   flush_o/redirect_pc_o                                   : mispredict redirect
//   err_o                                                   : sticky empty-resolve
//   resolved_cnt_o/mispred_cnt_o                            : statistics
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    input  logic [PC_W-1:0]  pred_target_i,
    input  logic [PC_W-1:0]  pred_fallthru_i,
    output logic             full_o,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    output logic             update_o,
    output logic             result_o,
    output logic             flush_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             err_o,
    output logic [CNT_W-1:0] resolved_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Queue storage
    logic [DEPTH-1:0] taken_q;
    logic [PC_W-1:0]  target_q   [DEPTH];
    logic [PC_W-1:0]  fallthru_q [DEPTH];

    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;

    logic            update_q, result_q, flush_q, err_q;
    logic [PC_W-1:0] redirect_q, redirect_d;

    logic            empty, full;
    logic            head_taken;
    logic [PC_W-1:0] head_target, head_fallthru;
    logic            res_ok, mispred, push;

    assign empty = (rd_q == wr_q);
    assign full  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);

    assign head_taken    = taken_q[rd_q[AW-1:0]];
    assign head_target   = target_q[rd_q[AW-1:0]];
    assign head_fallthru = fallthru_q[rd_q[AW-1:0]];

    // A resolve only counts when there is a head entry to compare against.
    assign res_ok  = res_valid_i && !empty;
    assign mispred = res_ok && (res_taken_i != head_taken);

    // While full, a push is still accepted if the head pops in the same
    // cycle; a mispredict discards the push since it is wrong-path.
    assign push = pred_valid_i && !mispred && (!full || res_ok);

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        redirect_d = redirect_q;
        if (mispred) begin
            rd_d       = '0;
            wr_d       = '0;
            redirect_d = res_taken_i ? head_target : head_fallthru;
        end else begin
            if (push)   wr_d = wr_q + PW'(1);
            if (res_ok) rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_q       <= '0;
            wr_q       <= '0;
            update_q   <= 1'b0;
            result_q   <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            redirect_q <= '0;
            taken_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                target_q[i]   <= '0;
                fallthru_q[i] <= '0;
            end
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            redirect_q <= redirect_d;
            update_q   <= res_ok;
            result_q   <= res_ok && res_taken_i;
            flush_q    <= mispred;
            if (res_valid_i && empty) err_q <= 1'b1;
            if (push) begin
                taken_q[wr_q[AW-1:0]]    <= pred_taken_i;
                target_q[wr_q[AW-1:0]]   <= pred_target_i;
                fallthru_q[wr_q[AW-1:0]] <= pred_fallthru_i;
            end
        end
    end

    assign full_o        = full;
    assign update_o      = update_q;
    assign result_o      = result_q;
    assign flush_o       = flush_q;
    assign redirect_pc_o = redirect_q;
    assign err_o         = err_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Saturating counters, updated alongside the update strobe.
    always_comb begin
        resolved_cnt_d = resolved_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;
        if (res_ok && !(&resolved_cnt_q))  resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
        if (mispred && !(&mispred_cnt_q))  mispred_cnt_d  = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            resolved_cnt_q <= resolved_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    assign resolved_cnt_o = resolved_cnt_q;
    assign mispred_cnt_o  = mispred_cnt_q;
`else
    assign resolved_cnt_o = '0;
    assign mispred_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int PC_W  = 32;
    localparam int CNT_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             pred_valid_i, pred_taken_i;
    logic [PC_W-1:0]  pred_target_i, pred_fallthru_i;
    logic             full_o;
    logic             res_valid_i, res_taken_i;
    logic             update_o, result_o, flush_o, err_o;
    logic [PC_W-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] resolved_cnt_o, mispred_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    branch_resolve_unit #(.DEPTH(2), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pred_valid_i    (pred_valid_i),
        .pred_taken_i    (pred_taken_i),
        .pred_target_i   (pred_target_i),
        .pred_fallthru_i (pred_fallthru_i),
        .full_o          (full_o),
        .res_valid_i     (res_valid_i),
        .res_taken_i     (res_taken_i),
        .update_o        (update_o),
        .result_o        (result_o),
        .flush_o         (flush_o),
        .redirect_pc_o   (redirect_pc_o),
        .err_o           (err_o),
        .resolved_cnt_o  (resolved_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic pv, input logic pt, input logic [PC_W-1:0] tgt,
                        input logic [PC_W-1:0] ft, input logic rv, input logic rt);
        pred_valid_i    = pv;
        pred_taken_i    = pt;
        pred_target_i   = tgt;
        pred_fallthru_i = ft;
        res_valid_i     = rv;
        res_taken_i     = rt;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0;
        pred_valid_i = 1'b0; pred_taken_i = 1'b0;
        pred_target_i = '0; pred_fallthru_i = '0;
        res_valid_i = 1'b0; res_taken_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_update", update_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_full", full_o, 0);
        check("rst_err", err_o, 0);
        check("rst_redirect", redirect_pc_o, 0);
        rst_i = 1'b1;
        idle();

        // T2: correct prediction
        step(1, 1, 32'h40, 32'h14, 0, 0);
        check("t2_not_full", full_o, 0);
        step(0, 0, 0, 0, 1, 1);
        check("t2_update", update_o, 1);
        check("t2_result", result_o, 1);
        check("t2_flush", flush_o, 0);
        idle();
        check("t2_update_1cyc", update_o, 0);
        check("t2_result_1cyc", result_o, 0);

        // T3: mispredict clears queue
        step(1, 1, 32'h40, 32'h14, 0, 0);
        step(1, 1, 32'h80, 32'h24, 0, 0);
        check("t3_full", full_o, 1);
        step(0, 0, 0, 0, 1, 0);
        check("t3_flush", flush_o, 1);
        check("t3_redirect", redirect_pc_o, 32'h14);
        check("t3_update", update_o, 1);
        check("t3_result", result_o, 0);
        check("t3_empty", full_o, 0);
        idle();
        check("t3_flush_1cyc", flush_o, 0);
        check("t3_redirect_hold", redirect_pc_o, 32'h14);
        // new entry must be the head after the clear
        step(1, 1, 32'h100, 32'h30, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("t3_newhead_flush", flush_o, 0);
        check("t3_newhead_update", update_o, 1);

        // T4: full, dropped push, push+resolve while full
        step(1, 1, 32'h200, 32'h50, 0, 0);  // A
        step(1, 0, 32'h300, 32'h60, 0, 0);  // B
        check("t4_full", full_o, 1);
        step(1, 1, 32'h400, 32'h70, 0, 0);  // C dropped
        check("t4_full_after_drop", full_o, 1);
        step(1, 0, 32'h500, 32'h80, 1, 1);  // push D, resolve A correct
        check("t4_pr_update", update_o, 1);
        check("t4_pr_flush", flush_o, 0);
        check("t4_pr_full", full_o, 1);
        step(0, 0, 0, 0, 1, 0);             // resolve B correct
        check("t4_b_flush", flush_o, 0);
        step(0, 0, 0, 0, 1, 1);             // head must be D (not-taken) -> mispredict
        check("t4_d_flush", flush_o, 1);
        check("t4_d_redirect", redirect_pc_o, 32'h500);

        // T5: resolve while empty
        step(0, 0, 0, 0, 1, 1);
        check("t5_err", err_o, 1);
        check("t5_update", update_o, 0);
        check("t5_flush", flush_o, 0);
        idle();
        check("t5_err_sticky", err_o, 1);

        // T1: asynchronous reset mid-run with a pending mispredict
        step(1, 1, 32'h600, 32'h90, 0, 0);
        step(1, 1, 32'h700, 32'ha0, 0, 0);
        check("t1_pre_full", full_o, 1);
        pred_valid_i = 1'b0; res_valid_i = 1'b1; res_taken_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        check("t1_async_full", full_o, 0);
        check("t1_async_err", err_o, 0);
        check("t1_async_redirect", redirect_pc_o, 0);
        check("t1_async_flush", flush_o, 0);
        res_valid_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        idle();
        check("t1_no_update", update_o, 0);
        check("t1_no_flush", flush_o, 0);

        // T6: five mispredicts, counters saturate at 3 (or read 0)
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h800, 32'hb0, 0, 0);
            step(0, 0, 0, 0, 1, 0);
            if (i == 1) begin
`ifdef BRU_STATS_EN
                check("t6_mis_2", mispred_cnt_o, 2);
                check("t6_res_2", resolved_cnt_o, 2);
`else
                check("t6_mis_2", mispred_cnt_o, 0);
                check("t6_res_2", resolved_cnt_o, 0);
`endif
            end
        end
        check("t6_flush", flush_o, 1);
        check("t6_redirect", redirect_pc_o, 32'hb0);
`ifdef BRU_STATS_EN
        check("t6_mis_sat", mispred_cnt_o, 3);
        check("t6_res_sat", resolved_cnt_o, 3);
`else
        check("t6_mis_zero", mispred_cnt_o, 0);
        check("t6_res_zero", resolved_cnt_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
